// File: rtl/ysyx_mem_arb.sv
// Single-port memory arbiter between the IFU fetch path and the LSU load/store path.
// Define YSYX_MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU priority.
module ysyx_mem_arb #(
  parameter int unsigned BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_avalid,
  input  logic [BIT_W-1:0] ifu_addr,
  output logic             ifu_rvalid,
  output logic [BIT_W-1:0] ifu_rdata,
  input  logic             lsu_avalid,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [BIT_W-1:0] lsu_wdata,
  output logic             lsu_rvalid,
  output logic [BIT_W-1:0] lsu_rdata,
  output logic             lsu_wready,
  output logic             mem_avalid,
  output logic [BIT_W-1:0] mem_addr,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [BIT_W-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [BIT_W-1:0] mem_rdata,
  input  logic             mem_wready
);

  typedef enum logic [1:0] {StIdle, StIfu, StLsuRd, StLsuWr} state_e;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic             ren_q, ren_d, wen_q, wen_d;
  logic             last_q, last_d;
  logic             drop_q, drop_d;
  logic             grant_lsu, lsu_write, owner_valid, busy, live;

  // A store needs wen without ren; anything else from the LSU is treated as a load.
  assign lsu_write = lsu_wen && !lsu_ren;

`ifdef YSYX_MEM_ARB_RR_EN
  assign grant_lsu = lsu_avalid && (!ifu_avalid || !last_q);
`else
  assign grant_lsu = lsu_avalid;
`endif

  assign owner_valid = (state_q == StIfu) ? ifu_avalid : lsu_avalid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          state_d = lsu_write ? StLsuWr : StLsuRd;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          ren_d   = !lsu_write;
          wen_d   = lsu_write;
          last_d  = 1'b1;
        end else if (ifu_avalid) begin
          state_d = StIfu;
          addr_d  = ifu_addr;
          wdata_d = '0;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      StIfu, StLsuRd: begin
        drop_d = drop_q || !owner_valid;
        if (mem_rvalid) state_d = StIdle;
      end
      StLsuWr: begin
        drop_d = drop_q || !owner_valid;
        if (mem_wready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  // Once the owner has withdrawn its request, the memory transfer still finishes
  // but its response pulse is swallowed.
  assign busy = (state_q != StIdle);
  assign live = owner_valid && !drop_q;

  always_comb begin
    mem_avalid = busy;
    mem_addr   = busy ? addr_q : '0;
    mem_ren    = busy && ren_q;
    mem_wen    = busy && wen_q;
    mem_wdata  = busy ? wdata_q : '0;
    ifu_rvalid = (state_q == StIfu) && mem_rvalid && live;
    ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
    lsu_rvalid = (state_q == StLsuRd) && mem_rvalid && live;
    lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    lsu_wready = (state_q == StLsuWr) && mem_wready && live;
  end

endmodule
